// File: rtl/raizing_video_pkg.sv
// Shared types, constants and helpers for the Raizing video colour path.
package raizing_video_pkg;

  localparam int unsigned PAL_AW = 11;
  localparam int unsigned IDX_W  = 11;
  localparam int unsigned WORD_W = 15;

  localparam logic [IDX_W-1:0] BACKDROP_IDX = '0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // A layer pixel is transparent when its low nibble is zero.
  function automatic logic is_opaque(input logic [IDX_W-1:0] idx);
    return (idx & IDX_W'(4'hF)) != '0;
  endfunction

  // Bit replication so full scale maps to full scale.
  function automatic logic [7:0] exp5to8(input logic [4:0] x);
    return {x, x[4:2]};
  endfunction

endpackage

// File: rtl/raizing_pal555.sv
// Output stage: holds the palette word, expands xBGR555 to RGB888 and forces blanking.
module raizing_pal555
  import raizing_video_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixel_cen_i,
  input  logic [WORD_W-1:0] pal_data_i,
  input  logic              live_i,
  input  logic              hb_i,
  input  logic              vb_i,
  output rgb_t              rgb_o,
  output logic              hbo_o,
  output logic              vbo_o
);

  logic [WORD_W-1:0] word_q, word_d;
  rgb_t              rgb_q, rgb_d;
  logic              hbo_q, hbo_d;
  logic              vbo_q, vbo_d;

  always_comb begin
    word_d = word_q;
    rgb_d  = rgb_q;
    hbo_d  = hbo_q;
    vbo_d  = vbo_q;
    if (pixel_cen_i) begin
      word_d = pal_data_i;
      if (!live_i) begin
        // Pipeline not yet primed since reset: emit a blanked slot.
        rgb_d = '0;
        hbo_d = 1'b1;
        vbo_d = 1'b1;
      end else begin
        hbo_d = hb_i;
        vbo_d = vb_i;
        if (hb_i || vb_i) begin
          rgb_d = '0;
        end else begin
          rgb_d.r = exp5to8(word_q[4:0]);
          rgb_d.g = exp5to8(word_q[9:5]);
          rgb_d.b = exp5to8(word_q[14:10]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      rgb_q  <= '0;
      hbo_q  <= 1'b1;
      vbo_q  <= 1'b1;
    end else begin
      word_q <= word_d;
      rgb_q  <= rgb_d;
      hbo_q  <= hbo_d;
      vbo_q  <= vbo_d;
    end
  end

  assign rgb_o = rgb_q;
  assign hbo_o = hbo_q;
  assign vbo_o = vbo_q;

endmodule

// File: rtl/raizing_textmix.sv
// Raizing final colour stage: text/GP9001 priority, palette addressing, blank delay line.
// Optional macro RAIZING_TEXTMIX_LAYERDIS_EN adds LAYER_EN per-layer enables.
module raizing_textmix
  import raizing_video_pkg::*;
#(
  parameter int unsigned PAL_AW = raizing_video_pkg::PAL_AW,
  parameter int unsigned LAT    = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              PIXEL_CEN,
  input  logic              HB,
  input  logic              VB,
  input  logic [IDX_W-1:0]  EXTRATEXT_PIXEL,
  input  logic [IDX_W-1:0]  GP9001_PIXEL,
`ifdef RAIZING_TEXTMIX_LAYERDIS_EN
  input  logic [1:0]        LAYER_EN,
`endif
  output logic [PAL_AW-1:0] PALRAM_ADDR,
  input  logic [15:0]       PALRAM_DATA,
  output logic [7:0]        RED,
  output logic [7:0]        GREEN,
  output logic [7:0]        BLUE,
  output logic              HBO,
  output logic              VBO
);

  logic             ext_op, gp_op;
  logic [IDX_W-1:0] sel_idx;

  logic [PAL_AW-1:0] addr_q, addr_d;
  logic [LAT-1:0]    valid_q, valid_d;
  logic [1:0]        blank1_q, blank1_d;
  logic [1:0]        blank2_q, blank2_d;

  rgb_t rgb;
  logic unused_pal_msb;

  // Layer visibility; disabled layers are treated as transparent.
  always_comb begin
`ifdef RAIZING_TEXTMIX_LAYERDIS_EN
    ext_op = is_opaque(EXTRATEXT_PIXEL) && LAYER_EN[1];
    gp_op  = is_opaque(GP9001_PIXEL) && LAYER_EN[0];
`else
    ext_op = is_opaque(EXTRATEXT_PIXEL);
    gp_op  = is_opaque(GP9001_PIXEL);
`endif
  end

  always_comb begin
    sel_idx = BACKDROP_IDX;
    if (ext_op) begin
      sel_idx = EXTRATEXT_PIXEL;
    end else if (gp_op) begin
      sel_idx = GP9001_PIXEL;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    valid_d  = valid_q;
    blank1_d = blank1_q;
    blank2_d = blank2_q;
    if (PIXEL_CEN) begin
      addr_d   = PAL_AW'(sel_idx);
      valid_d  = {valid_q[LAT-2:0], 1'b1};
      blank1_d = {HB, VB};
      blank2_d = blank1_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q   <= '0;
      valid_q  <= '0;
      blank1_q <= '0;
      blank2_q <= '0;
    end else begin
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      blank1_q <= blank1_d;
      blank2_q <= blank2_d;
    end
  end

  // Bit 15 of the palette word carries no colour.
  assign unused_pal_msb = PALRAM_DATA[15];

  raizing_pal555 u_pal555 (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .pixel_cen_i (PIXEL_CEN),
    .pal_data_i  (PALRAM_DATA[WORD_W-1:0]),
    .live_i      (valid_q[LAT-1]),
    .hb_i        (blank2_q[1]),
    .vb_i        (blank2_q[0]),
    .rgb_o       (rgb),
    .hbo_o       (HBO),
    .vbo_o       (VBO)
  );

  assign PALRAM_ADDR = addr_q;
  assign RED         = rgb.r;
  assign GREEN       = rgb.g;
  assign BLUE        = rgb.b;

endmodule
